// File: rtl/round_robin_cmerge_arbiter.sv
// Registered round-robin merge for dataless control tokens. It holds one token in a
// single slot and forks it to a token channel and an index channel; each channel drains on its own.
module round_robin_cmerge_arbiter #(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       ins_valid,
    output logic [SIZE-1:0]       ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [INDEX_TYPE-1:0] index,
    output logic                  index_valid,
    input  logic                  index_ready
);
    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(SIZE - 1);

    logic             slot_full_q, slot_full_d;
    logic [PTR_W-1:0] slot_idx_q, slot_idx_d;
    logic             sent_outs_q, sent_outs_d;
    logic             sent_index_q, sent_index_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             done_o, done_i, drain, can_load, any_valid, accept;
    logic [PTR_W-1:0] win;

    assign outs_valid  = slot_full_q & ~sent_outs_q;
    assign index_valid = slot_full_q & ~sent_index_q;
    assign done_o      = sent_outs_q | (outs_valid & outs_ready);
    assign done_i      = sent_index_q | (index_valid & index_ready);
    assign drain       = slot_full_q & done_o & done_i;
    // Gating with rst keeps every grant low while reset is held.
    assign can_load    = (~slot_full_q | drain) & rst;
    assign accept      = any_valid & can_load;

    always_comb begin
        index = '0;
        index[PTR_W-1:0] = slot_idx_q;
    end

    // Rotating scan: the first valid input at or after ptr wins.
    always_comb begin
        int cand;
        any_valid = 1'b0;
        win       = '0;
        cand      = 0;
        for (int off = 0; off < SIZE; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= SIZE) cand = cand - SIZE;
            if (!any_valid && ins_valid[cand]) begin
                any_valid = 1'b1;
                win       = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        ins_ready = '0;
        if (accept) ins_ready[win] = 1'b1;
    end

    always_comb begin
        slot_full_d  = slot_full_q;
        slot_idx_d   = slot_idx_q;
        sent_outs_d  = sent_outs_q;
        sent_index_d = sent_index_q;
        ptr_d        = ptr_q;
        if (accept) begin
            slot_full_d  = 1'b1;
            slot_idx_d   = win;
            sent_outs_d  = 1'b0;
            sent_index_d = 1'b0;
            ptr_d        = (win == LAST) ? '0 : win + 1'b1;
        end else if (drain) begin
            slot_full_d  = 1'b0;
            sent_outs_d  = 1'b0;
            sent_index_d = 1'b0;
        end else if (slot_full_q) begin
            sent_outs_d  = done_o;
            sent_index_d = done_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full_q  <= 1'b0;
            slot_idx_q   <= '0;
            sent_outs_q  <= 1'b0;
            sent_index_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            slot_full_q  <= slot_full_d;
            slot_idx_q   <= slot_idx_d;
            sent_outs_q  <= sent_outs_d;
            sent_index_q <= sent_index_d;
            ptr_q        <= ptr_d;
        end
    end
endmodule

// File: tb/tb_round_robin_cmerge_arbiter.sv
// Directed bench for round_robin_cmerge_arbiter: a SIZE=4 instance and a SIZE=1 instance.
module tb_round_robin_cmerge_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ins_valid = '0;
    logic [3:0] ins_ready;
    logic       outs_valid, outs_ready = 1'b0;
    logic [1:0] index;
    logic       index_valid, index_ready = 1'b0;

    logic [0:0] s1_ins_valid = '0;
    logic [0:0] s1_ins_ready;
    logic       s1_outs_valid;
    logic [0:0] s1_index;
    logic       s1_index_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    round_robin_cmerge_arbiter #(.SIZE(4), .INDEX_TYPE(2)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs_valid(outs_valid), .outs_ready(outs_ready),
        .index(index), .index_valid(index_valid), .index_ready(index_ready)
    );

    round_robin_cmerge_arbiter #(.SIZE(1), .INDEX_TYPE(1)) dut1 (
        .clk(clk), .rst(rst),
        .ins_valid(s1_ins_valid), .ins_ready(s1_ins_ready),
        .outs_valid(s1_outs_valid), .outs_ready(outs_ready),
        .index(s1_index), .index_valid(s1_index_valid), .index_ready(index_ready)
    );

    // Advance to 1ns after the next rising edge; inputs are changed there and checked 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        ins_valid = 4'b1111; outs_ready = 1'b1; index_ready = 1'b1;
        rst = 1'b0;
        tick(); settle();
        tests++;
        if (outs_valid !== 1'b0 || index_valid !== 1'b0 || index !== 2'd0 || ins_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold got ov=%b iv=%b idx=%0d rdy=%b exp 0 0 0 0000", outs_valid, index_valid, index, ins_ready);
        end
        rst = 1'b1; settle();
        tests++;
        if (ins_ready !== 4'b0001) begin
            fails++; $display("FAIL reset_first_grant got %b exp 0001", ins_ready);
        end
        // Fill the slot (token 0, ptr then 1) and stall, then reset mid-transfer.
        outs_ready = 1'b0; index_ready = 1'b0;
        tick();
        tests++;
        if (outs_valid !== 1'b1 || index !== 2'd0) begin
            fails++; $display("FAIL reset_slot_full got ov=%b idx=%0d exp 1 0", outs_valid, index);
        end
        #2 rst = 1'b0; #1;
        tests++;
        if (outs_valid !== 1'b0 || index_valid !== 1'b0 || ins_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_async got ov=%b iv=%b rdy=%b exp 0 0 0000", outs_valid, index_valid, ins_ready);
        end
        tick();
        rst = 1'b1; outs_ready = 1'b1; index_ready = 1'b1; settle();
        tests++;
        if (ins_ready !== 4'b0001) begin
            fails++; $display("FAIL reset_ptr_cleared got %b exp 0001", ins_ready);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        ins_valid = 4'b1111; outs_ready = 1'b1; index_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            tests++;
            if (ins_ready !== (4'b0001 << (k % 4))) begin
                fails++; $display("FAIL rot_ready k=%0d got %b exp %b", k, ins_ready, 4'b0001 << (k % 4));
            end
            if (k > 0) begin
                tests++;
                if (outs_valid !== 1'b1 || index_valid !== 1'b1 || index !== 2'((k - 1) % 4)) begin
                    fails++; $display("FAIL rot_index k=%0d got ov=%b iv=%b idx=%0d exp 1 1 %0d", k, outs_valid, index_valid, index, (k - 1) % 4);
                end
            end
            tick();
        end
        ins_valid = '0;
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        outs_ready = 1'b1; index_ready = 1'b1;
        ins_valid = 4'b0100;
        tick();
        ins_valid = 4'b0010; settle();
        tests++;
        if (ins_ready !== 4'b0010) begin
            fails++; $display("FAIL wrap_ready got %b exp 0010", ins_ready);
        end
        tick();
        ins_valid = 4'b1111; settle();
        tests++;
        if (index !== 2'd1 || outs_valid !== 1'b1) begin
            fails++; $display("FAIL wrap_index got idx=%0d ov=%b exp 1 1", index, outs_valid);
        end
        tests++;
        if (ins_ready !== 4'b0100) begin
            fails++; $display("FAIL wrap_next_ptr got %b exp 0100", ins_ready);
        end
        tick();
        ins_valid = '0;
    endtask

    task automatic test_fork_skew();
        do_reset();
        outs_ready = 1'b1; index_ready = 1'b1;
        ins_valid = 4'b0001;
        tick();
        ins_valid = 4'b0010; outs_ready = 1'b1; index_ready = 1'b0; settle();
        tests++;
        if (outs_valid !== 1'b1 || index_valid !== 1'b1 || index !== 2'd0 || ins_ready !== 4'b0000) begin
            fails++; $display("FAIL skew_c1 got ov=%b iv=%b idx=%0d rdy=%b exp 1 1 0 0000", outs_valid, index_valid, index, ins_ready);
        end
        tick();
        outs_ready = 1'b0; index_ready = 1'b1; settle();
        tests++;
        if (outs_valid !== 1'b0 || index_valid !== 1'b1 || index !== 2'd0 || ins_ready !== 4'b0010) begin
            fails++; $display("FAIL skew_c2 got ov=%b iv=%b idx=%0d rdy=%b exp 0 1 0 0010", outs_valid, index_valid, index, ins_ready);
        end
        tick();
        ins_valid = '0; settle();
        tests++;
        if (outs_valid !== 1'b1 || index_valid !== 1'b1 || index !== 2'd1) begin
            fails++; $display("FAIL skew_reload got ov=%b iv=%b idx=%0d exp 1 1 1", outs_valid, index_valid, index);
        end
        outs_ready = 1'b1; tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        outs_ready = 1'b0; index_ready = 1'b0;
        ins_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            tests++;
            if (outs_valid !== 1'b1 || index_valid !== 1'b1 || index !== 2'd0 || ins_ready !== 4'b0000) begin
                fails++; $display("FAIL bp_hold c=%0d got ov=%b iv=%b idx=%0d rdy=%b exp 1 1 0 0000", c, outs_valid, index_valid, index, ins_ready);
            end
            tick();
        end
        outs_ready = 1'b1; index_ready = 1'b1; settle();
        tests++;
        if (ins_ready !== 4'b0010) begin
            fails++; $display("FAIL bp_release got %b exp 0010", ins_ready);
        end
        tick();
        ins_valid = '0; settle();
        tests++;
        if (outs_valid !== 1'b1 || index !== 2'd1) begin
            fails++; $display("FAIL bp_next got ov=%b idx=%0d exp 1 1", outs_valid, index);
        end
        tick();
    endtask

    task automatic test_size1();
        logic [4:0] pat;
        logic       prev;
        do_reset();
        outs_ready = 1'b1; index_ready = 1'b1;
        pat = 5'b01011;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s1_ins_valid = (k < 5) ? pat[k] : 1'b0;
            settle();
            tests++;
            if (s1_ins_ready !== s1_ins_valid || s1_outs_valid !== prev || s1_index_valid !== prev || s1_index !== 1'b0) begin
                fails++; $display("FAIL size1 k=%0d got rdy=%b ov=%b iv=%b idx=%0d exp %b %b %b 0", k, s1_ins_ready, s1_outs_valid, s1_index_valid, s1_index, s1_ins_valid, prev, prev);
            end
            prev = s1_ins_valid[0];
            tick();
        end
        s1_ins_valid = '0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse_wrap();
        test_fork_skew();
        test_backpressure();
        test_size1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
